// File: rtl/video_mem_pkg.sv
// rtl/video_mem_pkg.sv - shared states and constants for the frame buffer memory arbiter
package video_mem_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT,
    ARB,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    GAP,
    FAULT
  } state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam int DEF_ADDR_WIDTH   = 21;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_BURST_WORDS  = 8;
  localparam int DEF_CMD_GAP      = 2;
  localparam int DEF_READ_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with read priority override
module rr_arbiter2 (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req_rd,
  input  logic i_req_wr,
  input  logic i_urgent,
  input  logic i_take,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);

  logic r_last_wr;
  logic w_rd_wins_tie;

  // A tie goes to read when it is urgent or when write was served last
  always_comb begin
    w_rd_wins_tie = i_urgent || r_last_wr;
    o_gnt_rd      = i_req_rd && (!i_req_wr || w_rd_wins_tie);
    o_gnt_wr      = i_req_wr && (!i_req_rd || !w_rd_wins_tie);
  end

  // Remember which side won each arbitration the controller actually took
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_wr <= 1'b1;
    end else if (i_take && (o_gnt_rd || o_gnt_wr)) begin
      r_last_wr <= o_gnt_wr;
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// rtl/sdram_burst_arbiter.sv - shares one SDRAM controller port between a burst writer and a burst reader
module sdram_burst_arbiter
  import video_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BURST_WORDS  = DEF_BURST_WORDS,
  parameter int CMD_GAP      = DEF_CMD_GAP,
  parameter int READ_TIMEOUT = DEF_READ_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_init_done,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data_in,
  output logic                  o_wr_grant,
  output logic                  o_wr_data_ack,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_urgent,
  output logic                  o_rd_grant,
  output logic [DATA_WIDTH-1:0] o_rd_data_out,
  output logic                  o_rd_data_valid_out,
  output logic                  o_rd_done,
  output logic                  o_cmd,
  output logic                  o_cmd_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [3:0]            o_data_mask,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_data_valid,
  input  logic                  i_mem_error,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int BEAT_W = $clog2(BURST_WORDS + 1);
  localparam int TMO_W  = $clog2(READ_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(CMD_GAP + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(READ_TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CMD_GAP - 1);

  state_t                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [TMO_W-1:0]      r_tmo;
  logic [GAP_W-1:0]      r_gap;
  logic                  r_cmd_en;
  logic                  r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_grant;
  logic                  r_rd_grant;
  logic                  r_wr_active;
  logic [DATA_WIDTH-1:0] r_rd_data_out;
  logic                  r_rd_valid_out;
  logic                  r_rd_done;
  logic                  r_error;

  logic                  w_arb_slot;
  logic                  w_gnt_rd;
  logic                  w_gnt_wr;
  logic [TMO_W-1:0]      w_tmo_next;

  // The last GAP cycle doubles as an arbitration slot so back-to-back
  // bursts see exactly CMD_GAP idle command cycles between them
  always_comb begin
    w_arb_slot = (r_state == ARB) || ((r_state == GAP) && (r_gap == GAP_LAST));
    w_tmo_next = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TMO_W'(1);
  end

  rr_arbiter2 u_rr (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req_rd (i_rd_req),
    .i_req_wr (i_wr_req),
    .i_urgent (i_rd_urgent),
    .i_take   (w_arb_slot && !i_mem_error),
    .o_gnt_rd (w_gnt_rd),
    .o_gnt_wr (w_gnt_wr)
  );

  // Main burst sequencer; strobes default low every cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= WAIT_INIT;
      r_beat         <= '0;
      r_tmo          <= '0;
      r_gap          <= '0;
      r_cmd_en       <= 1'b0;
      r_cmd          <= 1'b0;
      r_addr         <= '0;
      r_wr_grant     <= 1'b0;
      r_rd_grant     <= 1'b0;
      r_wr_active    <= 1'b0;
      r_rd_data_out  <= '0;
      r_rd_valid_out <= 1'b0;
      r_rd_done      <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_cmd_en       <= 1'b0;
      r_wr_grant     <= 1'b0;
      r_rd_grant     <= 1'b0;
      r_rd_valid_out <= 1'b0;
      r_rd_done      <= 1'b0;
      if ((r_state != WAIT_INIT) && i_mem_error) begin
        r_state     <= FAULT;
        r_error     <= 1'b1;
        r_wr_active <= 1'b0;
      end else begin
        case (r_state)
          WAIT_INIT: begin
            if (i_init_done) r_state <= ARB;
          end
          ARB, GAP: begin
            if (!w_arb_slot) begin
              r_gap <= r_gap + GAP_W'(1);
            end else if (w_gnt_wr) begin
              r_state     <= WR_BURST;
              r_cmd_en    <= 1'b1;
              r_cmd       <= CMD_WRITE;
              r_addr      <= i_wr_addr;
              r_wr_grant  <= 1'b1;
              r_wr_active <= 1'b1;
              r_beat      <= '0;
            end else if (w_gnt_rd) begin
              r_state    <= RD_WAIT;
              r_cmd_en   <= 1'b1;
              r_cmd      <= CMD_READ;
              r_addr     <= i_rd_addr;
              r_rd_grant <= 1'b1;
              r_beat     <= '0;
              r_tmo      <= '0;
            end else begin
              r_state <= ARB;
            end
          end
          WR_BURST: begin
            r_beat <= r_beat + BEAT_W'(1);
            if (r_beat == LAST_BEAT) begin
              r_wr_active <= 1'b0;
              r_state     <= GAP;
              r_gap       <= '0;
            end
          end
          RD_WAIT, RD_BURST: begin
            if (i_rd_data_valid) begin
              r_rd_data_out  <= i_rd_data;
              r_rd_valid_out <= 1'b1;
              r_beat         <= r_beat + BEAT_W'(1);
              if (r_beat == LAST_BEAT) begin
                r_rd_done <= 1'b1;
                r_state   <= GAP;
                r_gap     <= '0;
              end else begin
                r_state <= RD_BURST;
              end
            end else if (r_state == RD_WAIT) begin
              r_tmo <= w_tmo_next;
              if (w_tmo_next == TMO_MAX) begin
                r_state <= FAULT;
                r_error <= 1'b1;
              end
            end
          end
          FAULT: begin
            r_error     <= 1'b1;
            r_wr_active <= 1'b0;
          end
          default: r_state <= WAIT_INIT;
        endcase
      end
    end
  end

  // Write data is passed straight through so each ack names the word on the bus this cycle
  always_comb begin
    o_wr_data     = r_wr_active ? i_wr_data_in : '0;
    o_wr_data_ack = r_wr_active;
    o_busy        = (r_state != WAIT_INIT) && (r_state != ARB);
  end

  assign o_wr_grant          = r_wr_grant;
  assign o_rd_grant          = r_rd_grant;
  assign o_rd_data_out       = r_rd_data_out;
  assign o_rd_data_valid_out = r_rd_valid_out;
  assign o_rd_done           = r_rd_done;
  assign o_cmd               = r_cmd;
  assign o_cmd_en            = r_cmd_en;
  assign o_addr              = r_addr;
  assign o_data_mask         = 4'b0000;
  assign o_error             = r_error;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb/tb_sdram_burst_arbiter.sv - directed self-checking bench for sdram_burst_arbiter
module tb_sdram_burst_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_init_done = 1'b0;
  logic          i_wr_req = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data_in;
  logic          i_rd_req = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          i_rd_urgent = 1'b0;
  logic [DW-1:0] i_rd_data = '0;
  logic          i_rd_data_valid = 1'b0;
  logic          i_mem_error = 1'b0;

  logic          o_wr_grant, o_wr_data_ack, o_rd_grant, o_rd_data_valid_out, o_rd_done;
  logic          o_cmd, o_cmd_en, o_error, o_busy;
  logic [DW-1:0] o_rd_data_out, o_wr_data;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_data_mask;

  sdram_burst_arbiter dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_init_done         (i_init_done),
    .i_wr_req            (i_wr_req),
    .i_wr_addr           (i_wr_addr),
    .i_wr_data_in        (i_wr_data_in),
    .o_wr_grant          (o_wr_grant),
    .o_wr_data_ack       (o_wr_data_ack),
    .i_rd_req            (i_rd_req),
    .i_rd_addr           (i_rd_addr),
    .i_rd_urgent         (i_rd_urgent),
    .o_rd_grant          (o_rd_grant),
    .o_rd_data_out       (o_rd_data_out),
    .o_rd_data_valid_out (o_rd_data_valid_out),
    .o_rd_done           (o_rd_done),
    .o_cmd               (o_cmd),
    .o_cmd_en            (o_cmd_en),
    .o_addr              (o_addr),
    .o_wr_data           (o_wr_data),
    .o_data_mask         (o_data_mask),
    .i_rd_data           (i_rd_data),
    .i_rd_data_valid     (i_rd_data_valid),
    .i_mem_error         (i_mem_error),
    .o_error             (o_error),
    .o_busy              (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Observation logs, appended only by the monitor
  int            cmd_cyc[$];
  logic          cmd_kind[$];
  logic [AW-1:0] cmd_addr[$];
  logic          gnt_seq[$];
  logic [DW-1:0] wr_words[$];
  int            wr_cyc[$];
  logic [DW-1:0] rdo_words[$];
  int            rdo_cyc[$];
  int            rdi_cyc[$];
  int            done_cyc[$];

  // Uploader: presents word (acks since mark + 1), advancing on each ack
  int ack_total = 0;
  int ack_mark  = 0;
  assign i_wr_data_in = DW'(ack_total - ack_mark + 1);

  // Controller read model settings (written by the main sequence)
  bit m_ret_en = 1'b1;
  int m_lat    = 5;
  int m_bub    = -1;
  int m_t      = -1;
  int m_j      = 0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_cmd_en) begin
        cmd_cyc.push_back(cyc);
        cmd_kind.push_back(o_cmd);
        cmd_addr.push_back(o_addr);
      end
      if (o_wr_grant) gnt_seq.push_back(1'b1);
      if (o_rd_grant) gnt_seq.push_back(1'b0);
      if (o_wr_data_ack) begin
        wr_words.push_back(o_wr_data);
        wr_cyc.push_back(cyc);
        ack_total = ack_total + 1;
      end
      if (o_rd_data_valid_out) begin
        rdo_words.push_back(o_rd_data_out);
        rdo_cyc.push_back(cyc);
      end
      if (o_rd_done) done_cyc.push_back(cyc);
      if (i_reset) m_t = -1;
      else if (o_cmd_en && !o_cmd && m_ret_en) begin
        m_t = 0;
        m_j = 0;
      end else if (m_t >= 0) m_t = m_t + 1;
      i_rd_data_valid = 1'b0;
      if (m_t >= 0 && m_j < 8 &&
          m_t == m_lat + m_j + ((m_bub >= 0 && m_j >= m_bub) ? 1 : 0)) begin
        i_rd_data_valid = 1'b1;
        i_rd_data = DW'(32'hA0 + m_j);
        rdi_cyc.push_back(cyc);
        m_j = m_j + 1;
        if (m_j == 8) m_t = -1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_grants(input string tag, input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge i_clk);
      if (o_wr_grant || o_rd_grant) got++;
    end
    check(tag, 64'(got), 64'(n));
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, 64'({o_wr_grant, o_wr_data_ack, o_rd_grant, o_rd_data_valid_out,
                                  o_rd_done, o_cmd, o_cmd_en, o_error, o_busy, o_data_mask}), 64'd0);
    check({tag, "_addr"}, 64'(o_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(o_wr_data), 64'd0);
    check({tag, "_rd_data"}, 64'(o_rd_data_out), 64'd0);
  endtask

  initial begin
    int c0, w0, r0, i0, d0, g0, t_init, t_err;

    // Reset state
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check_quiet("reset");
    i_reset = 1'b0;

    // Write requested before init_done: nothing issued
    c0 = cmd_cyc.size();
    i_wr_addr = 21'h2E6;
    ack_mark = ack_total;
    i_wr_req = 1'b1;
    repeat (10) @(negedge i_clk);
    check("no_cmd_before_init", 64'(cmd_cyc.size() - c0), 64'd0);
    check("idle_not_busy", 64'(o_busy), 64'd0);

    // Two back-to-back write bursts once initialised
    w0 = wr_words.size();
    i_init_done = 1'b1;
    t_init = cyc;
    wait_grants("wr_grants", 2, 60);
    i_wr_req = 1'b0;
    repeat (20) @(negedge i_clk);
    check("wr_cmd_count", 64'(cmd_cyc.size() - c0), 64'd2);
    check("wr_cmd_latency", 64'(cmd_cyc[c0]), 64'(t_init + 2));
    check("wr_cmd_kind", 64'(cmd_kind[c0]), 64'd1);
    check("wr_cmd_addr", 64'(cmd_addr[c0]), 64'h2E6);
    check("wr_burst_period", 64'(cmd_cyc[c0 + 1] - cmd_cyc[c0]), 64'd10);
    check("wr_ack_count", 64'(wr_words.size() - w0), 64'd16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wr_word%0d", k), 64'(wr_words[w0 + k]), 64'(k + 1));
      check($sformatf("wr_beat_cyc%0d", k), 64'(wr_cyc[w0 + k]), 64'(cmd_cyc[c0 + k / 8] + k % 8));
    end

    // Single read, first word after 5 cycles, bubble before word 3
    m_ret_en = 1'b1;
    m_lat = 5;
    m_bub = 3;
    c0 = cmd_cyc.size();
    r0 = rdo_words.size();
    i0 = rdi_cyc.size();
    d0 = done_cyc.size();
    g0 = gnt_seq.size();
    i_rd_addr = 21'h100;
    i_rd_req = 1'b1;
    wait_grants("rd_grant", 1, 20);
    i_rd_req = 1'b0;
    repeat (25) @(negedge i_clk);
    check("rd_cmd_count", 64'(cmd_cyc.size() - c0), 64'd1);
    check("rd_cmd_kind", 64'(cmd_kind[c0]), 64'd0);
    check("rd_cmd_addr", 64'(cmd_addr[c0]), 64'h100);
    check("rd_grant_side", 64'(gnt_seq[g0]), 64'd0);
    check("rd_word_count", 64'(rdo_words.size() - r0), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rd_word%0d", k), 64'(rdo_words[r0 + k]), 64'(32'hA0 + k));
      check($sformatf("rd_word_lat%0d", k), 64'(rdo_cyc[r0 + k]), 64'(rdi_cyc[i0 + k] + 1));
    end
    check("rd_done_count", 64'(done_cyc.size() - d0), 64'd1);
    check("rd_done_cyc", 64'(done_cyc[d0]), 64'(rdo_cyc[r0 + 7]));

    // Contention without urgency: alternation starting with read after reset
    pulse_reset();
    m_lat = 2;
    m_bub = -1;
    g0 = gnt_seq.size();
    i_wr_addr = 21'h3000;
    i_rd_addr = 21'h4000;
    i_rd_urgent = 1'b0;
    i_wr_req = 1'b1;
    i_rd_req = 1'b1;
    wait_grants("rr_grants", 4, 200);
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    repeat (20) @(negedge i_clk);
    check("rr_0_read", 64'(gnt_seq[g0]), 64'd0);
    check("rr_1_write", 64'(gnt_seq[g0 + 1]), 64'd1);
    check("rr_2_read", 64'(gnt_seq[g0 + 2]), 64'd0);
    check("rr_3_write", 64'(gnt_seq[g0 + 3]), 64'd1);

    // Urgent read wins every arbitration
    g0 = gnt_seq.size();
    i_rd_urgent = 1'b1;
    i_wr_req = 1'b1;
    i_rd_req = 1'b1;
    wait_grants("urgent_grants", 3, 200);
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    i_rd_urgent = 1'b0;
    repeat (20) @(negedge i_clk);
    for (int k = 0; k < 3; k++) check($sformatf("urgent_read%0d", k), 64'(gnt_seq[g0 + k]), 64'd0);

    // Read timeout: no data returned
    pulse_reset();
    m_ret_en = 1'b0;
    c0 = cmd_cyc.size();
    g0 = gnt_seq.size();
    i_rd_addr = 21'h55;
    i_rd_req = 1'b1;
    wait_grants("to_grant", 1, 20);
    i_rd_req = 1'b0;
    t_err = -1000;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_error) begin
        t_err = cyc;
        break;
      end
    end
    check("timeout_cycle", 64'(t_err - cmd_cyc[c0]), 64'd64);
    i_wr_req = 1'b1;
    repeat (20) @(negedge i_clk);
    check("fault_no_cmd", 64'(cmd_cyc.size() - c0), 64'd1);
    check("fault_no_grant", 64'(gnt_seq.size() - g0), 64'd1);
    check("error_sticky", 64'(o_error), 64'd1);
    i_wr_req = 1'b0;
    pulse_reset();
    m_ret_en = 1'b1;
    @(negedge i_clk);
    check("reset_clears_error", 64'(o_error), 64'd0);

    // Controller error while arbitrating
    i_mem_error = 1'b1;
    @(negedge i_clk);
    i_mem_error = 1'b0;
    check("mem_error_fault", 64'(o_error), 64'd1);
    pulse_reset();

    // Reset during beat 3 of a write burst
    c0 = cmd_cyc.size();
    w0 = wr_words.size();
    ack_mark = ack_total;
    i_wr_addr = 21'h77;
    i_wr_req = 1'b1;
    wait_grants("abort_grant", 1, 20);
    i_wr_req = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    i_init_done = 1'b0;
    @(negedge i_clk);
    check("abort_ack_stops", 64'(o_wr_data_ack), 64'd0);
    check_quiet("abort");
    check("abort_beats", 64'(wr_words.size() - w0), 64'd4);
    i_reset = 1'b0;
    i_wr_req = 1'b1;
    repeat (8) @(negedge i_clk);
    check("abort_wait_init", 64'(cmd_cyc.size() - c0), 64'd1);
    check("abort_not_busy", 64'(o_busy), 64'd0);
    i_wr_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
